// File: rtl/gsm_pkg.sv
// Shared types and constants for the GSM SMS alarm sender: FSM states, segment
// layout and the 42-byte AT command message image.
package gsm_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam int MSG_LEN = 42;
  localparam logic [4:0] SEG_LEN  [0:2] = '{5'd10, 5'd22, 5'd10};
  localparam logic [5:0] SEG_BASE [0:2] = '{6'd0, 6'd10, 6'd32};
  localparam logic [7:0] CTRL_Z = 8'h1A;

  // Byte 0 sits in the most significant byte of the image.
  localparam logic [8*MSG_LEN-1:0] MSG =
    {"AT+CMGF=1\r", "AT+CMGS=\"13800000000\"\r", "TEMP HIGH", CTRL_Z};

  function automatic logic [4:0] seg_len(input logic [1:0] s);
    case (s)
      2'd0:    return SEG_LEN[0];
      2'd1:    return SEG_LEN[1];
      default: return SEG_LEN[2];
    endcase
  endfunction

  function automatic logic [5:0] seg_base(input logic [1:0] s);
    case (s)
      2'd0:    return SEG_BASE[0];
      2'd1:    return SEG_BASE[1];
      default: return SEG_BASE[2];
    endcase
  endfunction

endpackage

// File: rtl/gsm_msg_rom.sv
// Combinational 42x8 ROM holding the three AT command segments back to back.
module gsm_msg_rom
  import gsm_pkg::*;
(
  input  logic [5:0] addr,
  output logic [7:0] data
);

  always_comb begin
    data = 8'h00;
    if (addr < 6'(MSG_LEN))
      data = MSG[8*(MSG_LEN-1-int'(addr)) +: 8];
  end

endmodule

// File: rtl/gsm_sms_sender.sv
// Streams the fixed three-segment SMS AT sequence to the UART on each alarm
// request, with idle gaps after segments 0 and 1 and a one-deep request queue.
//
// state | meaning
// IDLE  | waiting for trig or a pending request
// SEND  | presenting bytes of segment seg, idx is the byte on the bus
// GAP   | idle delay of GAP_CYCLES cycles before the next segment
// DONE  | one-cycle done pulse, then back to IDLE
module gsm_sms_sender
  import gsm_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       done
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        state, state_n;
  logic [1:0]    seg, seg_n;
  logic [4:0]    idx, idx_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          pending, pending_n;
  logic          tx_valid_n, busy_n, done_n;
  logic [7:0]    tx_data_n;
  logic [5:0]    rom_addr;
  logic [7:0]    rom_data;

  gsm_msg_rom u_rom (
    .addr(rom_addr),
    .data(rom_data)
  );

  // The ROM is addressed with the byte that will be loaded onto the bus next.
  always_comb begin
    case (state)
      SEND:    rom_addr = seg_base(seg) + {1'b0, idx} + 6'd1;
      GAP:     rom_addr = seg_base(seg + 2'd1);
      default: rom_addr = 6'd0;
    endcase
  end

  always_comb begin
    state_n    = state;
    seg_n      = seg;
    idx_n      = idx;
    gap_n      = gap_cnt;
    pending_n  = pending | (trig && (state != IDLE));
    tx_valid_n = tx_valid;
    tx_data_n  = tx_data;
    busy_n     = busy;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (trig || pending) begin
          state_n    = SEND;
          seg_n      = 2'd0;
          idx_n      = 5'd0;
          busy_n     = 1'b1;
          tx_valid_n = 1'b1;
          tx_data_n  = rom_data;
          pending_n  = 1'b0;
        end
      end
      SEND: begin
        if (tx_valid && tx_ready) begin
          if (idx == seg_len(seg) - 5'd1) begin
            tx_valid_n = 1'b0;
            if (seg == 2'd2) begin
              state_n = DONE;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end else begin
              state_n = GAP;
              gap_n   = '0;
            end
          end else begin
            idx_n     = idx + 5'd1;
            tx_data_n = rom_data;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          state_n    = SEND;
          seg_n      = seg + 2'd1;
          idx_n      = 5'd0;
          tx_valid_n = 1'b1;
          tx_data_n  = rom_data;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      seg      <= 2'd0;
      idx      <= 5'd0;
      gap_cnt  <= '0;
      pending  <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      seg      <= seg_n;
      idx      <= idx_n;
      gap_cnt  <= gap_n;
      pending  <= pending_n;
      tx_valid <= tx_valid_n;
      tx_data  <= tx_data_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_gsm_sms_sender.sv
// Bench for gsm_sms_sender: a byte-position model of the message stream checked
// every cycle, plus literal expectations for latency, gap length and text.
module tb_gsm_sms_sender;

  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic       tx_ready = 1'b1;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
  logic       done;

  gsm_sms_sender #(.GAP_CYCLES(GAP)) dut (
    .clk(clk),
    .rst(rst),
    .trig(trig),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit stall = 1'b0;
  logic [7:0] got[$];
  int got_cyc[$];
  byte unsigned msg[42];

  // Model: position in the 42-byte message, remaining gap cycles, pending flag.
  bit m_active = 1'b0;
  bit m_done = 1'b0;
  bit m_pend = 1'b0;
  int m_pos = 0;
  int m_gap = 0;

  function automatic bit m_valid();
    return m_active && (m_gap == 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0; m_done = 1'b0; m_pend = 1'b0; m_pos = 0; m_gap = 0;
    end else begin
      if ((m_active || m_done) && trig) m_pend = 1'b1;
      if (m_done) begin
        m_done = 1'b0;
      end else if (!m_active) begin
        if (trig || m_pend) begin
          m_active = 1'b1; m_pos = 0; m_gap = 0; m_pend = 1'b0;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (tx_ready) begin
        m_pos++;
        if (m_pos == 10 || m_pos == 32) m_gap = GAP;
        else if (m_pos == 42) begin
          m_active = 1'b0; m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    chk("tx_valid", tx_valid, m_valid());
    chk("busy", busy, m_active);
    chk("done", done, m_done);
    if (m_valid()) chk("tx_data", tx_data, msg[m_pos]);
    if (tx_valid && tx_ready && !rst) begin
      got.push_back(tx_data);
      got_cyc.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic tick(input bit t, input bit r);
    @(posedge clk);
    #2;
    trig = t;
    rst = r;
    tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick(0, 0);
      n++;
    end
    chk("done_reached", done_cnt, target);
  endtask

  task automatic run_xfers(input int target, input int budget);
    int n = 0;
    while (got.size() < target && n < budget) begin
      tick(0, 0);
      n++;
    end
    chk("xfers_reached", got.size(), target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    string s0;
    int base, d0, seen, bad, n;
    s = {"AT+CMGF=1\r", "AT+CMGS=\"13800000000\"\r", "TEMP HIGH"};
    s0 = "AT+CMGF=1\r";
    for (int i = 0; i < 41; i++) msg[i] = s[i];
    msg[41] = 8'h1A;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick(0, 0);

    // Quiet without requests
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(0, 0);
      seen = seen | int'(tx_valid) | int'(busy) | int'(done);
    end
    chk("idle_quiet", seen, 0);

    // Single request, ready held high
    base = got.size(); d0 = done_cnt;
    tick(1, 0);
    chk("pre_accept_valid", tx_valid, 0);
    tick(0, 0);
    chk("latency_valid", tx_valid, 1);
    chk("first_byte", tx_data, 8'h41);
    chk("busy_on", busy, 1);
    run_done(d0 + 1, 300);
    chk("t1_count", got.size() - base, 42);
    bad = 0;
    for (int i = 0; i < 10; i++) if (got[base+i] !== 8'(s0[i])) bad++;
    chk("seg0_text", bad, 0);
    chk("last_byte", got[base+41], 8'h1A);
    chk("gap0_len", got_cyc[base+10] - got_cyc[base+9], 9);
    chk("gap1_len", got_cyc[base+32] - got_cyc[base+31], 9);
    chk("seg_inner", got_cyc[base+11] - got_cyc[base+10], 1);
    chk("t1_done_once", done_cnt - d0, 1);

    // Random back-pressure
    stall = 1'b1;
    base = got.size(); d0 = done_cnt;
    tick(1, 0);
    run_done(d0 + 1, 3000);
    stall = 1'b0;
    chk("t2_count", got.size() - base, 42);
    bad = 0;
    for (int i = 0; i < 42 && base + i < got.size(); i++) if (got[base+i] !== msg[i]) bad++;
    chk("t2_order", bad, 0);

    // Overlapping requests collapse into one extra sequence
    base = got.size(); d0 = done_cnt;
    tick(1, 0);
    run_xfers(base + 15, 200);
    tick(1, 0);
    repeat (3) tick(0, 0);
    tick(1, 0);
    run_done(d0 + 2, 600);
    repeat (40) tick(0, 0);
    chk("t3_count", got.size() - base, 84);
    chk("t3_dones", done_cnt - d0, 2);
    chk("t3_second_start", got[base+42], 8'h41);
    chk("t3_idle_busy", busy, 0);

    // Request in the done cycle
    base = got.size(); d0 = done_cnt;
    tick(1, 0);
    n = 0;
    while (!m_done && n < 300) begin
      tick(0, 0);
      n++;
    end
    chk("t4_done_now", done, 1);
    trig = 1'b1;
    tick(0, 0);
    chk("t4_idle_valid", tx_valid, 0);
    chk("t4_idle_busy", busy, 0);
    tick(0, 0);
    chk("t4_restart_valid", tx_valid, 1);
    chk("t4_restart_byte", tx_data, 8'h41);
    run_done(d0 + 2, 300);
    chk("t4_count", got.size() - base, 84);

    // Reset mid-sequence with a pending request
    base = got.size(); d0 = done_cnt;
    tick(1, 0);
    run_xfers(base + 12, 200);
    tick(1, 0);
    run_xfers(base + 15, 200);
    rst = 1'b1;
    tick(0, 0);
    chk("t5_valid", tx_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    repeat (30) tick(0, 0);
    chk("t5_discard", got.size() - base, 15);
    tick(1, 0);
    run_done(d0 + 1, 300);
    chk("t5_restart_byte", got[base+15], 8'h41);
    chk("t5_count", got.size() - base, 57);

    repeat (5) tick(0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
